// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store access controller.
// DataType encodings, FSM states and the size-mask decode.
package lsu_pkg;

  localparam logic [1:0] DT_BYTE = 2'b00;
  localparam logic [1:0] DT_HALF = 2'b01;
  localparam logic [1:0] DT_WORD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    RESP = 2'd3
  } state_t;

  // Reserved type 2'b10 falls through to a full word.
  function automatic logic [3:0] sizeMask(input logic [1:0] dt);
    logic [3:0] m;
    case (dt)
      DT_BYTE: m = 4'b0001;
      DT_HALF: m = 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic isMisaligned(
    input logic [1:0] dt,
    input logic [1:0] off
  );
    return ((dt == DT_HALF) && (off == 2'd3)) ||
           (dt[1] && (off != 2'd0));
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-enable and store-lane alignment for one memory phase.
// Phase 0 is the low word, phase 1 the spill-over into the next word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  dataType,
  input  logic        phase,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] laneData
);

  logic [3:0] mask;
  logic [2:0] rsh;

  assign mask = sizeMask(dataType);
  assign rsh  = 3'd4 - {1'b0, off};

  always_comb begin
    if (!phase) begin
      be       = mask << off;
      laneData = wdata << {off, 3'b000};
    end else begin
      be       = mask >> rsh;
      laneData = wdata >> {rsh, 3'b000};
    end
  end

endmodule

// File: rtl/lsu_access_ctrl.sv
// Load/store sequencer: byte enables, lane shifting, load extension.
// LSU_MISALIGN_SPLIT_EN splits misaligned accesses; else they fault.
module lsu_access_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_type,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_fault
);

  state_t      state;
  logic        weReg;
  logic        unsReg;
  logic        faultReg;
  logic [1:0]  offReg;
  logic [1:0]  typeReg;
  logic [31:0] loReg;
  logic [23:0] hiWord;

  logic [1:0]  laneOff;
  logic [1:0]  laneType;
  logic        lanePhase;
  logic [31:0] laneWdata;
  logic [3:0]  laneBe;
  logic [31:0] laneData;
  logic        reqMis;

  logic [31:0] merged;
  logic [31:0] loadData;

  assign reqMis = isMisaligned(req_type, req_addr[1:0]);

`ifdef LSU_MISALIGN_SPLIT_EN
  logic        splitReg;
  logic [31:0] wdataReg;
  logic [23:0] hiReg;
  logic        inIdle;

  // Phase 1 re-aligns from the fields captured at acceptance.
  assign inIdle    = (state == IDLE);
  assign laneOff   = inIdle ? req_addr[1:0] : offReg;
  assign laneType  = inIdle ? req_type : typeReg;
  assign laneWdata = inIdle ? req_wdata : wdataReg;
  assign lanePhase = (state == ACC0);
  assign hiWord    = hiReg;
`else
  assign laneOff   = req_addr[1:0];
  assign laneType  = req_type;
  assign laneWdata = req_wdata;
  assign lanePhase = 1'b0;
  assign hiWord    = '0;
`endif

  lsu_lane_align uAlign (
    .off      (laneOff),
    .dataType (laneType),
    .phase    (lanePhase),
    .wdata    (laneWdata),
    .be       (laneBe),
    .laneData (laneData)
  );

  always_comb begin
    merged = loReg;
    unique case (offReg)
      2'd0: merged = loReg;
      2'd1: merged = {hiWord[7:0], loReg[31:8]};
      2'd2: merged = {hiWord[15:0], loReg[31:16]};
      2'd3: merged = {hiWord[23:0], loReg[31:24]};
    endcase
    loadData = merged;
    if (typeReg == DT_BYTE)
      loadData = {{24{~unsReg & merged[7]}}, merged[7:0]};
    else if (typeReg == DT_HALF)
      loadData = {{16{~unsReg & merged[15]}}, merged[15:0]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_fault <= 1'b0;
      weReg     <= 1'b0;
      unsReg    <= 1'b0;
      faultReg  <= 1'b0;
      offReg    <= '0;
      typeReg   <= '0;
      loReg     <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
      splitReg  <= 1'b0;
      wdataReg  <= '0;
      hiReg     <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            weReg     <= req_we;
            unsReg    <= req_unsigned;
            offReg    <= req_addr[1:0];
            typeReg   <= req_type;
            loReg     <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
            splitReg  <= reqMis;
            wdataReg  <= req_wdata;
            hiReg     <= '0;
            faultReg  <= 1'b0;
            state     <= ACC0;
            mem_req   <= 1'b1;
`else
            faultReg  <= reqMis;
            state     <= reqMis ? RESP : ACC0;
            mem_req   <= ~reqMis;
`endif
            mem_we    <= req_we;
            mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
            mem_be    <= laneBe;
            mem_wdata <= laneData;
          end
        end
        ACC0: begin
          if (mem_ack) begin
            loReg <= mem_rdata;
`ifdef LSU_MISALIGN_SPLIT_EN
            if (splitReg) begin
              state     <= ACC1;
              mem_addr  <= mem_addr + ADDR_W'(4);
              mem_be    <= laneBe;
              mem_wdata <= laneData;
            end else begin
              state   <= RESP;
              mem_req <= 1'b0;
            end
`else
            state   <= RESP;
            mem_req <= 1'b0;
`endif
          end
        end
`ifdef LSU_MISALIGN_SPLIT_EN
        ACC1: begin
          if (mem_ack) begin
            hiReg   <= mem_rdata[23:0];
            state   <= RESP;
            mem_req <= 1'b0;
          end
        end
`endif
        RESP: begin
          // First RESP cycle builds the response; second presents it.
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
            rsp_fault <= faultReg;
            rsp_rdata <= (weReg || faultReg) ? 32'h0 : loadData;
          end else begin
            rsp_valid <= 1'b0;
            faultReg  <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          mem_req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/lsu_access_ctrl.md
Name: lsu_access_ctrl

Overview:
- Load/store sequencer between the core's memory stage and the word-addressed data memory port.
- Accepts one byte, halfword or word access per request and derives the 4-bit byte enables from address[1:0] and the data type.
- Lane-shifts store data, issues one or two aligned memory transactions with a valid/ack handshake, and merges, sign-extends or zero-extends load data.
- Sits between the ALU-result/DataType stage and the data memory; it replaces the core's direct byte-enable path.

Parameters:
- ADDR_W, 32, byte-address width. mem_addr[1:0] is always 0.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  access request.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address (the ALU result).
- req_type  in  2  DataType: 00 byte, 01 halfword, 11 word, 10 reserved (treated as word).
- req_unsigned  in  1  zero-extend load when 1.
- req_wdata  in  32  store data, right-justified.
- mem_req  out  1  memory transaction valid.
- mem_we  out  1  write strobe.
- mem_addr  out  ADDR_W  word-aligned address.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-aligned store data.
- mem_ack  in  1  transaction complete; mem_rdata valid in the same cycle.
- mem_rdata  in  32  read word.
- rsp_valid  out  1  one-cycle pulse when the access is complete.
- rsp_rdata  out  32  extended load data (0 for stores).
- rsp_fault  out  1  misaligned access rejected; qualified by rsp_valid.

Behaviour:
- States: IDLE, ACC0, ACC1, RESP.
- Reset values: state=IDLE, req_ready=1, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_rdata=0, rsp_fault=0.
- Reset mid-operation: the next edge forces the reset values. An outstanding mem_ack is ignored and no response is produced.
- req_ready=1 only in IDLE. A request is accepted when req_valid & req_ready; all request fields are registered at acceptance.
- Definitions: off = req_addr[1:0]; mask = 0001 for byte, 0011 for halfword, 1111 for word.
- Misaligned accesses: halfword with off=3, or word with off≠0.
- Aligned access, IDLE→ACC0:
  - mem_addr = addr & ~3
  - mem_be = mask << off
  - mem_wdata = wdata << 8*off
- mem_req is registered: it asserts in the cycle after acceptance and holds all mem_* fields stable until the cycle with mem_ack=1. An ack in the first mem_req cycle is legal.
- Aligned completion: ACC0 with ack → RESP. mem_req drops on the next edge.
- Misaligned completion: ACC0 with ack → ACC1. The second transaction asserts in the following cycle with:
  - mem_addr = (addr & ~3) + 4 (wraps modulo 2^ADDR_W)
  - mem_be = mask >> (4-off)
  - mem_wdata = wdata >> 8*(4-off)
- ACC1 with ack → RESP.
- Load data handling:
  - ACC0 captures mem_rdata; ACC1 captures the upper word.
  - Merged value = {hi, lo} >> 8*off, truncated to the access size.
  - Sign-extended unless req_unsigned.
  - A word load ignores req_unsigned.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE with req_ready=1.
  - Back-to-back throughput: an aligned access with zero-wait ack takes 4 cycles from acceptance to the next acceptance.
- mem_ack while mem_req=0 is ignored.
- Stores: rsp_rdata=0 and rsp_valid is still pulsed.

Optional Feature:
- LSU_MISALIGN_SPLIT_EN defined: misaligned accesses are split as above; rsp_fault is always 0.
- Not defined: a misaligned request goes IDLE→RESP without asserting mem_req, with rsp_fault=1 and rsp_rdata=0. ACC1 and its logic are omitted; aligned behaviour is identical.

Decomposition:
- lsu_pkg holds:
  - DataType constants DT_BYTE=2'b00, DT_HALF=2'b01, DT_WORD=2'b11
  - state encoding
  - size-mask function (type→4-bit mask)
- Sub-module lsu_lane_align (combinational): given off, type and phase (0/1), produces mem_be and the shifted store data. Instantiated once in the controller.

Test Plan:
- Reset held during ACC0 with mem_ack never asserted → next cycle mem_req=0, req_ready=1; a later stray mem_ack produces no rsp_valid.
- Byte store, addr=0x102, wdata=0xA5, zero-wait ack → one transaction: mem_addr=0x100, mem_be=0100, mem_wdata=0x00A50000; rsp_valid 3 cycles after acceptance.
- Word load, addr=0x200, ack delayed 3 cycles, mem_rdata=0xDEADBEEF → mem_be=1111, fields stable across waits, rsp_rdata=0xDEADBEEF.
- Signed halfword load, addr=0x06, mem_rdata=0x80010000 → mem_be=1100, rsp_rdata=0xFFFF8001; repeated with req_unsigned=1 → 0x00008001.
- Split enabled, word load at addr=0x0FF, first rdata=0x11223344, second 0x55667788 → mem_addr 0x0FC then 0x100, mem_be 1000 then 0111, rsp_rdata=0x66778811.
- Split disabled, same request → no mem_req; rsp_valid=1 with rsp_fault=1 two cycles after acceptance.
